// File: rtl/bus_bridge.sv
// CPU-side memory-mapped bus bridge: splits loads/stores between DRAM and a small
// peripheral block (7-segment display, free-running timer, LEDs, switches, buttons).
module bus_bridge #(
    parameter int unsigned SCAN_DIV = 20000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] Bus_addr,
    input  logic        Bus_wen,
    input  logic [31:0] Bus_wdata,
    output logic [31:0] Bus_rdata,
    output logic [13:0] dram_addr,
    output logic        dram_wen,
    output logic [31:0] dram_wdata,
    input  logic [31:0] dram_rdata,
    input  logic [23:0] sw,
    input  logic [4:0]  btn,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [2:0] {
        RGN_DRAM,
        RGN_DISP,
        RGN_TIMER,
        RGN_LED,
        RGN_SW,
        RGN_BTN,
        RGN_NONE
    } region_t;

    region_t          region;
    logic [31:0]      display;
    logic [31:0]      timer;
    logic [23:0]      sw_meta;
    logic [23:0]      sw_sync;
    logic [4:0]       btn_meta;
    logic [4:0]       btn_sync;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       idx;
    logic             div_last;
    logic [2:0]       idx_nxt;
    logic [31:0]      disp_nxt;
    logic [3:0]       nibble;
    logic             wr_disp;
    logic             wr_timer;
    logic             wr_led;

    // Peripheral window matched on word address; anything below it is DRAM.
    always_comb begin
        region = RGN_NONE;
        if (Bus_addr < 32'hFFFF_F000) begin
            region = RGN_DRAM;
        end else begin
            case (Bus_addr[31:2])
                30'h3FFF_FC00: region = RGN_DISP;
                30'h3FFF_FC08: region = RGN_TIMER;
                30'h3FFF_FC18: region = RGN_LED;
                30'h3FFF_FC1C: region = RGN_SW;
                30'h3FFF_FC1E: region = RGN_BTN;
                default:       region = RGN_NONE;
            endcase
        end
    end

    assign wr_disp    = Bus_wen && (region == RGN_DISP);
    assign wr_timer   = Bus_wen && (region == RGN_TIMER);
    assign wr_led     = Bus_wen && (region == RGN_LED);
    assign dram_wen   = Bus_wen && (region == RGN_DRAM);
    assign dram_addr  = Bus_addr[15:2];
    assign dram_wdata = Bus_wdata;

    always_comb begin
        Bus_rdata = '0;
        case (region)
            RGN_DRAM:  Bus_rdata = dram_rdata;
            RGN_DISP:  Bus_rdata = display;
            RGN_TIMER: Bus_rdata = timer;
            RGN_LED:   Bus_rdata = {8'h00, led};
            RGN_SW:    Bus_rdata = {8'h00, sw_sync};
            RGN_BTN:   Bus_rdata = {27'h0, btn_sync};
            default:   Bus_rdata = '0;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            display  <= '0;
            led      <= '0;
            timer    <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            if (wr_disp) display <= Bus_wdata;
            if (wr_led)  led     <= Bus_wdata[23:0];
            timer    <= wr_timer ? Bus_wdata : timer + 32'd1;
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            btn_meta <= btn;
            btn_sync <= btn_meta;
        end
    end

    // Scan outputs are registered from next-state values so they line up with idx
    // and reflect a display store on the same edge that writes the register.
    assign div_last = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign idx_nxt  = div_last ? idx + 3'd1 : idx;
    assign disp_nxt = wr_disp ? Bus_wdata : display;
    assign nibble   = disp_nxt[{idx_nxt, 2'b00} +: 4];

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            div_cnt <= '0;
            idx     <= '0;
            dig_en  <= 8'hFE;
            dig_seg <= 8'h03;
        end else begin
            div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
            idx     <= idx_nxt;
            dig_en  <= ~(8'd1 << idx_nxt);
            dig_seg <= seg_code(nibble);
        end
    end

    function automatic logic [7:0] seg_code(input logic [3:0] hex);
        logic [7:0] code;
        case (hex)
            4'h0: code = 8'h03;
            4'h1: code = 8'h9F;
            4'h2: code = 8'h25;
            4'h3: code = 8'h0D;
            4'h4: code = 8'h99;
            4'h5: code = 8'h49;
            4'h6: code = 8'h41;
            4'h7: code = 8'h1F;
            4'h8: code = 8'h01;
            4'h9: code = 8'h09;
            4'hA: code = 8'h11;
            4'hB: code = 8'hC1;
            4'hC: code = 8'h63;
            4'hD: code = 8'h85;
            4'hE: code = 8'h61;
            default: code = 8'h71;
        endcase
        return code;
    endfunction

endmodule

// File: tb/tb_bus_bridge.sv
// Directed bench for bus_bridge: vector table for decode/load/store paths plus
// hand sequences for reset, timer wrap, synchronizer latency and digit scanning.
module tb_bus_bridge;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic [31:0] Bus_addr;
    logic        Bus_wen;
    logic [31:0] Bus_wdata;
    logic [31:0] Bus_rdata;
    logic [13:0] dram_addr;
    logic        dram_wen;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;
    logic [23:0] sw;
    logic [4:0]  btn;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  dig_seg;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] A_DISP  = 32'hFFFF_F000;
    localparam logic [31:0] A_TIMER = 32'hFFFF_F020;
    localparam logic [31:0] A_LED   = 32'hFFFF_F060;
    localparam logic [31:0] A_SW    = 32'hFFFF_F070;
    localparam logic [31:0] A_BTN   = 32'hFFFF_F078;

    bus_bridge #(.SCAN_DIV(4)) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .Bus_addr   (Bus_addr),
        .Bus_wen    (Bus_wen),
        .Bus_wdata  (Bus_wdata),
        .Bus_rdata  (Bus_rdata),
        .dram_addr  (dram_addr),
        .dram_wen   (dram_wen),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .sw         (sw),
        .btn        (btn),
        .led        (led),
        .dig_en     (dig_en),
        .dig_seg    (dig_seg)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [31:0] drd;
        logic [31:0] exp_rdata;
        logic        exp_wen;
        logic [13:0] exp_daddr;
    } vec_t;

    vec_t vecs [14];

    logic [7:0] seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                 8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge cpu_clk);
        Bus_wen = 1'b0;
        cpu_rst = 1'b1;
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
    endtask

    logic [31:0] disp_m;
    logic [2:0]  idx_m;

    initial begin
        vecs[0]  = '{A_LED,          1'b1, 32'h00AB_CDEF, 32'h0,         32'h0000_0000, 1'b0, 14'h3C18};
        vecs[1]  = '{A_LED,          1'b0, 32'h0,         32'h0,         32'h00AB_CDEF, 1'b0, 14'h3C18};
        vecs[2]  = '{32'hFFFF_F063,  1'b0, 32'h0,         32'h0,         32'h00AB_CDEF, 1'b0, 14'h3C18};
        vecs[3]  = '{32'h0000_0104,  1'b1, 32'h1234_5678, 32'h0,         32'h0000_0000, 1'b1, 14'h0041};
        vecs[4]  = '{32'h0000_0104,  1'b0, 32'h0,         32'hCAFE_BABE, 32'hCAFE_BABE, 1'b0, 14'h0041};
        vecs[5]  = '{32'hFFFF_EFFC,  1'b0, 32'h0,         32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 14'h3BFF};
        vecs[6]  = '{32'hFFFF_F004,  1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_0000, 1'b0, 14'h3C01};
        vecs[7]  = '{A_DISP,         1'b1, 32'h8765_4321, 32'h2222_2222, 32'h0000_0000, 1'b0, 14'h3C00};
        vecs[8]  = '{32'hFFFF_F002,  1'b0, 32'h0,         32'h0,         32'h8765_4321, 1'b0, 14'h3C00};
        vecs[9]  = '{A_LED,          1'b1, 32'hFFFF_FFFF, 32'h0,         32'h00AB_CDEF, 1'b0, 14'h3C18};
        vecs[10] = '{A_LED,          1'b0, 32'h0,         32'h0,         32'h00FF_FFFF, 1'b0, 14'h3C18};
        vecs[11] = '{A_SW,           1'b0, 32'h0,         32'h0,         32'h0000_0000, 1'b0, 14'h3C1C};
        vecs[12] = '{A_BTN,          1'b0, 32'h0,         32'h0,         32'h0000_0000, 1'b0, 14'h3C1E};
        vecs[13] = '{32'hFFFF_FFFC,  1'b1, 32'h5555_AAAA, 32'h3333_3333, 32'h0000_0000, 1'b0, 14'h3FFF};

        cpu_rst    = 1'b0;
        Bus_addr   = A_TIMER;
        Bus_wen    = 1'b0;
        Bus_wdata  = '0;
        dram_rdata = '0;
        sw         = '0;
        btn        = '0;
        #1 cpu_rst = 1'b1;
        #1;
        check("rst_led",      {8'h0, led},     32'h0);
        check("rst_dig_en",   {24'h0, dig_en}, 32'hFE);
        check("rst_dig_seg",  {24'h0, dig_seg},32'h03);
        check("rst_timer",    Bus_rdata,       32'h0);
        Bus_addr = 32'h0000_0040;
        #1 check("rst_dram_wen", {31'h0, dram_wen}, 32'h0);

        @(negedge cpu_clk);
        Bus_addr = A_TIMER;
        cpu_rst  = 1'b0;
        @(posedge cpu_clk); #1;
        check("timer_first", Bus_rdata, 32'h1);
        @(posedge cpu_clk); #1;
        check("timer_second", Bus_rdata, 32'h2);

        for (int i = 0; i < 14; i++) begin
            @(negedge cpu_clk);
            Bus_addr   = vecs[i].addr;
            Bus_wen    = vecs[i].wen;
            Bus_wdata  = vecs[i].wdata;
            dram_rdata = vecs[i].drd;
            #1;
            check($sformatf("v%0d_rdata", i), Bus_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_dram_wen", i), {31'h0, dram_wen}, {31'h0, vecs[i].exp_wen});
            check($sformatf("v%0d_dram_addr", i), {18'h0, dram_addr}, {18'h0, vecs[i].exp_daddr});
            check($sformatf("v%0d_dram_wdata", i), dram_wdata, vecs[i].wdata);
        end

        // asynchronous reset between edges
        @(negedge cpu_clk);
        Bus_wen  = 1'b0;
        Bus_addr = A_LED;
        #1 check("led_before_rst", {8'h0, led}, 32'h00FF_FFFF);
        #2 cpu_rst = 1'b1;
        #1;
        check("async_led", {8'h0, led}, 32'h0);
        check("async_dig_en", {24'h0, dig_en}, 32'hFE);
        check("async_dig_seg", {24'h0, dig_seg}, 32'h03);
        check("async_led_load", Bus_rdata, 32'h0);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;

        // timer load and wrap
        @(negedge cpu_clk);
        Bus_addr  = A_TIMER;
        Bus_wen   = 1'b1;
        Bus_wdata = 32'hFFFF_FFFE;
        @(posedge cpu_clk); #1;
        Bus_wen = 1'b0;
        check("timer_load", Bus_rdata, 32'hFFFF_FFFE);
        @(posedge cpu_clk); #1;
        check("timer_max", Bus_rdata, 32'hFFFF_FFFF);
        @(posedge cpu_clk); #1;
        check("timer_wrap", Bus_rdata, 32'h0);

        // two-flop synchronizer latency and read-only inputs
        @(negedge cpu_clk);
        sw       = 24'h00_5A5A;
        btn      = 5'h15;
        Bus_addr = A_SW;
        #1 check("sw_edge0", Bus_rdata, 32'h0);
        @(posedge cpu_clk); #1;
        check("sw_edge1", Bus_rdata, 32'h0);
        @(posedge cpu_clk); #1;
        check("sw_edge2", Bus_rdata, 32'h0000_5A5A);
        Bus_wen   = 1'b1;
        Bus_wdata = 32'hFFFF_FFFF;
        #1 check("sw_store_dram_wen", {31'h0, dram_wen}, 32'h0);
        @(posedge cpu_clk); #1;
        Bus_wen = 1'b0;
        check("sw_after_store", Bus_rdata, 32'h0000_5A5A);
        Bus_addr = A_BTN;
        #1 check("btn_sync", Bus_rdata, 32'h0000_0015);

        // digit scan with SCAN_DIV=4
        reset_dut();
        disp_m = '0;
        check("scan_start_en", {24'h0, dig_en}, 32'hFE);
        check("scan_start_seg", {24'h0, dig_seg}, 32'h03);
        for (int k = 1; k <= 40; k++) begin
            if (k == 1 || k == 10) begin
                Bus_addr  = A_DISP;
                Bus_wen   = 1'b1;
                Bus_wdata = (k == 1) ? 32'h0000_00A5 : 32'h0000_0FA5;
            end else begin
                Bus_wen = 1'b0;
            end
            @(posedge cpu_clk);
            if (Bus_wen) disp_m = Bus_wdata;
            #1;
            idx_m = 3'((k / 4) % 8);
            check($sformatf("scan%0d_en", k), {24'h0, dig_en}, {24'h0, ~(8'd1 << idx_m)});
            check($sformatf("scan%0d_seg", k), {24'h0, dig_seg}, {24'h0, seg_tab[disp_m[{idx_m, 2'b00} +: 4]]});
            @(negedge cpu_clk);
        end
        Bus_wen = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_bridge.md
BUS_BRIDGE -- requirements
Module: bus_bridge

Interface
REQ-001 Reset is asynchronous and active-high; one clock; ports named cpu_clk and cpu_rst.
REQ-002 Parameter SCAN_DIV, default 20000: cpu_clk cycles each display digit is held.
REQ-003 cpu_clk  input  1  single clock; all state updates on rising edge.
REQ-004 cpu_rst  input  1  asynchronous, active-high reset.
REQ-005 Bus_addr  input  32  byte address from the CPU MEM stage.
REQ-006 Bus_wen  input  1  write strobe, one cycle per store.
REQ-007 Bus_wdata  input  32  store data.
REQ-008 Bus_rdata  output  32  load data; combinational from Bus_addr.
REQ-009 dram_addr  output  14  DRAM word address = Bus_addr[15:2].
REQ-010 dram_wen  output  1  DRAM write enable.
REQ-011 dram_wdata  output  32  = Bus_wdata.
REQ-012 dram_rdata  input  32  DRAM asynchronous read data.
REQ-013 sw  input  24  board switches, asynchronous.
REQ-014 btn  input  5  board buttons, asynchronous.
REQ-015 led  output  24  LED register.
REQ-016 dig_en  output  8  digit enables, active-low, one-hot.
REQ-017 dig_seg  output  8  segments {a,b,c,d,e,f,g,dp}, active-low.

Function
REQ-018 Decode: 0xFFFF_F000 display, 0xFFFF_F020 timer, 0xFFFF_F060 LED, 0xFFFF_F070 switch, 0xFFFF_F078 button; any address < 0xFFFF_F000 is DRAM; other addresses >= 0xFFFF_F000 are unmapped.
REQ-019 Peripheral decode compares Bus_addr[31:2] only; Bus_addr[1:0] ignored.
REQ-020 dram_wen = Bus_wen AND DRAM region; never asserted for peripheral or unmapped addresses.
REQ-021 Bus_rdata: DRAM region -> dram_rdata; display -> display register; timer -> timer count; LED -> {8'h0, led}; switch -> {8'h0, sw_sync}; button -> {27'h0, btn_sync}; unmapped -> 0.
REQ-022 Stores to display/LED update that register on the next edge; readable the following cycle.
REQ-023 Stores to switch, button, unmapped addresses have no effect.
REQ-024 sw and btn each pass a two-flop synchronizer; input change visible on Bus_rdata after exactly 2 edges.
REQ-025 Timer: 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF -> 0.
REQ-026 Timer store loads Bus_wdata; store wins over increment that cycle; increments resume the next cycle.
REQ-027 Scan: divider counts 0..SCAN_DIV-1; at SCAN_DIV-1 divider returns to 0 and digit index (3-bit) advances, wrapping 7 -> 0.
REQ-028 dig_en = ~(1 << index), registered.
REQ-029 dig_seg = hex decode of display[4*index+3 : 4*index], registered, dp always 1 (off); codes 0..F = 03,9F,25,0D,99,49,41,1F,01,09,11,C1,63,85,61,71.
REQ-030 Display register written mid-scan takes effect on the current digit within 1 cycle; scan position unaffected.

Reset
REQ-031 cpu_rst asserted (any time, including mid-store): led=0, display=0, timer=0, synchronizers=0, divider=0, index=0.
REQ-032 During reset: dig_en=8'hFE, dig_seg=8'h03, dram_wen follows REQ-020 combinationally (bench holds Bus_wen=0).
REQ-033 After release, timer reads 1 on the first edge, scan restarts at digit 0.

Verification
REQ-034 Store 0x00AB_CDEF to 0xFFFF_F060 -> led=24'hABCDEF next cycle, dram_wen=0, load returns 0x00AB_CDEF.
REQ-035 Store 0x1234_5678 to 0x0000_0104 -> dram_wen=1, dram_addr=14'h041, dram_wdata=0x1234_5678; load same address returns dram_rdata.
REQ-036 Store 0xFFFF_FFFE to timer -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on successive cycles.
REQ-037 SCAN_DIV=4, display=0x0000_00A5 -> digit 0 (dig_en FE, seg 49) 4 cycles, digit 1 (FD, 11), digit 2 (FB, 03), wraps to digit 0 after 32 cycles.
REQ-038 sw 0 -> 0x00_5A5A mid-cycle -> switch load returns 0 for one edge, 0x0000_5A5A after the second edge; store to 0xFFFF_F070 changes nothing.
REQ-039 Assert cpu_rst between edges with led=0xFFFFFF -> led=0, dig_en=FE immediately, before next edge.
